// File: rtl/gu_sched_pkg.sv
// Shared state encoding, pixel-field widths and frame-rate default for the GU draw scheduler.
package gu_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_NEXT  = 2'd3
    } sched_state_e;

    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 3;

    localparam int FRAME_DIV_DEFAULT = 833333;

endpackage

// File: rtl/gu_draw_scheduler_frame_tick_gen.sv
// Frame-rate divider: counts clk cycles and pulses frame on the last count of each period.
module frame_tick_gen
    import gu_sched_pkg::*;
#(
    parameter int FRAME_DIV = FRAME_DIV_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    output logic frame
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // Disabling parks the counter at zero so re-enabling always gives a full period.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (!enable || count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_ONE;
        end
    end

    assign frame = enable && (count == CNT_LAST);

endmodule

// File: rtl/gu_draw_scheduler.sv
// Per-frame GU scheduler: plots each GU in priority order and muxes its pixels onto the VGA port.
// Optional wait timer and timeout flag are built only when GU_SCHED_TIMEOUT_EN is defined.
module gu_draw_scheduler
    import gu_sched_pkg::*;
#(
    parameter int NUM_GU    = 3,
    parameter int FRAME_DIV = FRAME_DIV_DEFAULT,
    parameter int TIMEOUT   = 131072
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [NUM_GU-1:0]     gu_done,
    input  logic [NUM_GU-1:0]     gu_writeEn,
    input  logic [X_W*NUM_GU-1:0] gu_x,
    input  logic [Y_W*NUM_GU-1:0] gu_y,
    input  logic [C_W*NUM_GU-1:0] gu_colour,
    output logic [NUM_GU-1:0]     gu_plot,
    output logic                  frame,
    output logic [X_W-1:0]        vga_x,
    output logic [Y_W-1:0]        vga_y,
    output logic [C_W-1:0]        vga_colour,
    output logic                  vga_writeEn,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeout
);

    localparam int IDX_W = (NUM_GU > 1) ? $clog2(NUM_GU) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_GU - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    sched_state_e     state;
    sched_state_e     next_state;
    logic [IDX_W-1:0] idx;
    logic             tmo_hit;

    logic [X_W-1:0] x_arr [NUM_GU];
    logic [Y_W-1:0] y_arr [NUM_GU];
    logic [C_W-1:0] c_arr [NUM_GU];

    frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV)
    ) u_frame_tick_gen (
        .clk    (clk),
        .resetn (resetn),
        .enable (enable),
        .frame  (frame)
    );

    always_comb begin
        for (int i = 0; i < NUM_GU; i++) begin
            x_arr[i] = gu_x[i*X_W +: X_W];
            y_arr[i] = gu_y[i*Y_W +: Y_W];
            c_arr[i] = gu_colour[i*C_W +: C_W];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        gu_plot    = '0;
        case (state)
            S_IDLE: begin
                if (frame) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                gu_plot[idx] = 1'b1;
                next_state   = S_WAIT;
            end
            S_WAIT: begin
                if (gu_done[idx] || tmo_hit) begin
                    next_state = S_NEXT;
                end
            end
            S_NEXT: begin
                next_state = (idx == IDX_LAST) ? S_IDLE : S_ISSUE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx <= '0;
        end else if (state == S_IDLE) begin
            idx <= '0;
        end else if (state == S_NEXT && idx != IDX_LAST) begin
            idx <= idx + IDX_ONE;
        end
    end

    // A tick landing mid-pass is dropped; the flag records that a frame was skipped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun <= 1'b0;
        end else if (!enable) begin
            overrun <= 1'b0;
        end else if (frame && busy) begin
            overrun <= 1'b1;
        end
    end

`ifdef GU_SCHED_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    logic [TMR_W-1:0] wait_timer;

    assign tmo_hit = (state == S_WAIT) && (wait_timer == TMR_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_timer <= '0;
        end else if (state == S_ISSUE) begin
            wait_timer <= '0;
        end else if (state == S_WAIT && wait_timer != TMR_LAST) begin
            wait_timer <= wait_timer + TMR_ONE;
        end
    end

    // A done arriving on the terminal count still counts as a normal completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timeout <= 1'b0;
        end else if (!enable) begin
            timeout <= 1'b0;
        end else if (tmo_hit && !gu_done[idx]) begin
            timeout <= 1'b1;
        end
    end
`else
    // Without a timer the terminal count can only fire for a degenerate non-positive TIMEOUT.
    assign tmo_hit = (TIMEOUT < 1);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_writeEn <= 1'b0;
        end else if (state == S_WAIT) begin
            vga_x       <= x_arr[idx];
            vga_y       <= y_arr[idx];
            vga_colour  <= c_arr[idx];
            vga_writeEn <= gu_writeEn[idx];
        end else begin
            vga_writeEn <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gu_draw_scheduler.sv
// Directed bench for gu_draw_scheduler with behavioural GUs that raise done a set delay after plot.
module tb_gu_draw_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [2:0]  model_done;
    logic [2:0]  inject_done;
    logic [2:0]  gu_done;
    logic [2:0]  gu_writeEn;
    logic [26:0] gu_x;
    logic [23:0] gu_y;
    logic [8:0]  gu_colour;
    logic [2:0]  gu_plot;
    logic        frame;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_writeEn;
    logic        busy;
    logic        overrun;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    int delay [3];
    int mcnt  [3];

    logic [2:0] plot_log  [128];
    logic       frame_log [128];
    logic       busy_log  [128];
    logic       ovr_log   [128];
    logic       tmo_log   [128];
    logic       we_log    [128];
    logic [8:0] x_log     [128];
    logic [7:0] y_log     [128];
    logic [2:0] c_log     [128];

    assign gu_done = model_done | inject_done;

    gu_draw_scheduler #(
        .NUM_GU    (3),
        .FRAME_DIV (16),
        .TIMEOUT   (32)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .gu_done     (gu_done),
        .gu_writeEn  (gu_writeEn),
        .gu_x        (gu_x),
        .gu_y        (gu_y),
        .gu_colour   (gu_colour),
        .gu_plot     (gu_plot),
        .frame       (frame),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_writeEn (vga_writeEn),
        .busy        (busy),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // GU model: done pulses delay[i] cycles after plot is seen; a delay of 0 never answers.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            model_done[i] = 1'b0;
            if (!resetn) begin
                mcnt[i] = 0;
            end else if (gu_plot[i]) begin
                mcnt[i] = delay[i];
            end else if (mcnt[i] > 0) begin
                mcnt[i] = mcnt[i] - 1;
                if (mcnt[i] == 0) model_done[i] = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyReset();
        resetn = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        enable = 1'b1;
    endtask

    // Leaves the bench on the negedge where frame is high (window step 0).
    task automatic waitFrame();
        int n;
        n = 0;
        @(negedge clk);
        while (!frame && n < 64) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frame_seen", int'(frame), 1);
    endtask

    task automatic applyStimulus(input int n, input int inj_k, input logic [2:0] inj_mask);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            inject_done  = (k == inj_k) ? inj_mask : 3'b000;
            plot_log[k]  = gu_plot;
            frame_log[k] = frame;
            busy_log[k]  = busy;
            ovr_log[k]   = overrun;
            tmo_log[k]   = timeout;
            we_log[k]    = vga_writeEn;
            x_log[k]     = vga_x;
            y_log[k]     = vga_y;
            c_log[k]     = vga_colour;
        end
        inject_done = 3'b000;
    endtask

    function automatic int firstPlot(input int i, input int from, input int n);
        for (int k = from; k <= n; k++) begin
            if (plot_log[k][i]) return k;
        end
        return -1;
    endfunction

    function automatic int countPlot(input int i, input int n);
        int c;
        c = 0;
        for (int k = 1; k <= n; k++) c += int'(plot_log[k][i]);
        return c;
    endfunction

    initial begin
        int fc;
        resetn      = 1'b0;
        enable      = 1'b0;
        inject_done = 3'b000;
        gu_writeEn  = 3'b111;
        gu_x        = {9'd33, 9'd100, 9'd11};
        gu_y        = {8'd44, 8'd50, 8'd22};
        gu_colour   = {3'd2, 3'd5, 3'd1};
        delay[0] = 5; delay[1] = 5; delay[2] = 5;

        repeat (3) @(negedge clk);
        checkOutput("rst_plot",    int'(gu_plot), 0);
        checkOutput("rst_frame",   int'(frame), 0);
        checkOutput("rst_busy",    int'(busy), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        checkOutput("rst_timeout", int'(timeout), 0);
        checkOutput("rst_we",      int'(vga_writeEn), 0);
        checkOutput("rst_x",       int'(vga_x), 0);
        checkOutput("rst_y",       int'(vga_y), 0);
        checkOutput("rst_colour",  int'(vga_colour), 0);

        // Done-after-5 pass, with a stray done[2] during GU0's slot.
        resetn = 1'b1;
        enable = 1'b1;
        waitFrame();
        applyStimulus(33, 3, 3'b100);
        checkOutput("p_gu0_first", firstPlot(0, 1, 33), 1);
        checkOutput("p_gu1_first", firstPlot(1, 1, 33), 8);
        checkOutput("p_gu2_first", firstPlot(2, 1, 33), 15);
        checkOutput("p_gu0_count", countPlot(0, 33), 2);
        checkOutput("p_gu1_count", countPlot(1, 33), 1);
        checkOutput("p_gu2_count", countPlot(2, 33), 1);
        checkOutput("p_frame15",   int'(frame_log[15]), 0);
        checkOutput("p_frame16",   int'(frame_log[16]), 1);
        checkOutput("p_frame32",   int'(frame_log[32]), 1);
        checkOutput("p_busy21",    int'(busy_log[21]), 1);
        checkOutput("p_busy22",    int'(busy_log[22]), 0);
        checkOutput("p_ovr16",     int'(ovr_log[16]), 0);
        checkOutput("p_ovr17",     int'(ovr_log[17]), 1);
        checkOutput("m_gu0_x",     int'(x_log[3]), 11);
        checkOutput("m_gu0_we",    int'(we_log[3]), 1);
        checkOutput("m_issue_we",  int'(we_log[9]), 0);
        checkOutput("m_issue_x",   int'(x_log[9]), 11);
        checkOutput("m_gu1_x",     int'(x_log[10]), 100);
        checkOutput("m_gu1_y",     int'(y_log[10]), 50);
        checkOutput("m_gu1_c",     int'(c_log[10]), 5);
        checkOutput("m_gu1_we",    int'(we_log[10]), 1);
        checkOutput("m_gu1_last",  int'(we_log[14]), 1);
        checkOutput("m_next_we",   int'(we_log[15]), 0);
        checkOutput("m_hold_x",    int'(x_log[15]), 100);

        // Drop enable just after the second pass starts; it must finish, then stay idle.
        enable = 1'b0;
        applyStimulus(40, 0, 3'b000);
        fc = 0;
        for (int k = 1; k <= 40; k++) fc += int'(frame_log[k]);
        checkOutput("d_ovr_clear", int'(ovr_log[1]), 0);
        checkOutput("d_gu1_plot",  firstPlot(1, 1, 40), 7);
        checkOutput("d_gu2_plot",  firstPlot(2, 1, 40), 14);
        checkOutput("d_gu0_none",  countPlot(0, 40), 0);
        checkOutput("d_busy20",    int'(busy_log[20]), 1);
        checkOutput("d_busy40",    int'(busy_log[40]), 0);
        checkOutput("d_frames",    fc, 0);

        // Done-after-10 pass overruns two ticks; only the third tick starts a new pass.
        delay[0] = 10; delay[1] = 10; delay[2] = 10;
        enable = 1'b1;
        waitFrame();
        applyStimulus(50, 0, 3'b000);
        checkOutput("o_gu0_first", firstPlot(0, 1, 50), 1);
        checkOutput("o_gu2_first", firstPlot(2, 1, 50), 25);
        checkOutput("o_gu0_again", firstPlot(0, 2, 50), 49);
        checkOutput("o_ovr17",     int'(ovr_log[17]), 1);
        checkOutput("o_busy36",    int'(busy_log[36]), 1);
        checkOutput("o_busy37",    int'(busy_log[37]), 0);

        // Reset in the middle of GU1's wait.
        delay[0] = 5; delay[1] = 5; delay[2] = 5;
        applyReset();
        waitFrame();
        applyStimulus(10, 0, 3'b000);
        checkOutput("r_pre_x", int'(x_log[10]), 100);
        resetn = 1'b0;
        #1;
        checkOutput("r_plot",    int'(gu_plot), 0);
        checkOutput("r_busy",    int'(busy), 0);
        checkOutput("r_we",      int'(vga_writeEn), 0);
        checkOutput("r_x",       int'(vga_x), 0);
        checkOutput("r_overrun", int'(overrun), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        waitFrame();
        applyStimulus(8, 0, 3'b000);
        checkOutput("r_gu0_first", firstPlot(0, 1, 8), 1);
        checkOutput("r_gu1_first", firstPlot(1, 1, 8), 8);

        // GU1 done lands on the timer terminal count: done wins.
        delay[0] = 5; delay[1] = 32; delay[2] = 5;
        applyReset();
        waitFrame();
        applyStimulus(45, 0, 3'b000);
        checkOutput("s_gu2_plot", firstPlot(2, 1, 45), 42);
        checkOutput("s_tmo41",    int'(tmo_log[41]), 0);
        checkOutput("s_tmo44",    int'(tmo_log[44]), 0);

        // GU1 never answers.
        delay[0] = 5; delay[1] = 0; delay[2] = 5;
        applyReset();
        waitFrame();
`ifdef GU_SCHED_TIMEOUT_EN
        applyStimulus(45, 0, 3'b000);
        checkOutput("t_tmo40",    int'(tmo_log[40]), 0);
        checkOutput("t_tmo41",    int'(tmo_log[41]), 1);
        checkOutput("t_gu2_plot", firstPlot(2, 1, 45), 42);
`else
        applyStimulus(80, 0, 3'b000);
        checkOutput("t_gu2_none", firstPlot(2, 1, 80), -1);
        checkOutput("t_tmo80",    int'(tmo_log[80]), 0);
        checkOutput("t_busy80",   int'(busy_log[80]), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
